// File: rtl/alu_sequencer.sv
// Sequencer that steps an 8-entry program through an external combinational ALU.
// Holds the program memory, accumulator, last result and sticky overflow flag.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       prog_we,
    input  logic [2:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic       start,
    output logic [7:0] alu_op,
    output logic [3:0] alu_x,
    output logic [3:0] alu_y,
    input  logic [7:0] alu_result,
    output logic [3:0] acc,
    output logic [7:0] result,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       ovf
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_MOD  = 4'd10;
    localparam logic [3:0] OP_ALU_MAX = 4'd12;
    localparam logic [3:0] OP_LDI  = 4'd13;
    localparam logic [3:0] OP_HALT = 4'd15;
    localparam logic [7:0] HALT_WORD = 8'hF0;

    state_t     state;
    state_t     next_state;
    logic [7:0] mem [8];
    logic [2:0] pc;
    logic [7:0] ir;

    logic       idle_like;
    logic       accept;
    logic [7:0] fetch_word;
    logic [3:0] fetch_op;
    logic [3:0] fetch_operand;
    logic [3:0] exec_op;

    assign idle_like     = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
    // A simultaneous program write wins over start; the start request is dropped.
    assign accept        = idle_like && start && !prog_we;
    assign fetch_word    = mem[pc];
    assign fetch_op      = fetch_word[7:4];
    assign fetch_operand = fetch_word[3:0];
    assign exec_op       = ir[7:4];

    assign busy = (state == ST_FETCH) || (state == ST_EXEC);
    assign done = (state == ST_DONE);
    assign err  = (state == ST_ERROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default assignment first so every path drives next_state and no latch is inferred.
        next_state = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (accept) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (fetch_op == OP_HALT) begin
                    next_state = ST_DONE;
                end else if ((fetch_op == OP_DIV || fetch_op == OP_MOD) && fetch_operand == 4'd0) begin
                    next_state = ST_ERROR;
                end else begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                next_state = (pc == 3'd7) ? ST_DONE : ST_FETCH;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: reset here is a functional requirement (memory must come up full of HALT),
    // so this array is built from flops rather than an inferred RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= HALT_WORD;
            end
        end else if (prog_we && idle_like) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= 3'd0;
            ir     <= 8'h00;
            acc    <= 4'h0;
            result <= 8'h00;
            alu_op <= 8'h00;
            alu_x  <= 4'h0;
            alu_y  <= 4'h0;
            ovf    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (accept) begin
                        pc     <= 3'd0;
                        acc    <= 4'h0;
                        result <= 8'h00;
                        ovf    <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    ir <= fetch_word;
                    // ALU drive is only presented for pass-through opcodes that reach EXEC.
                    if (next_state == ST_EXEC && fetch_op <= OP_ALU_MAX) begin
                        alu_op <= {4'h0, fetch_op};
                        alu_x  <= acc;
                        alu_y  <= fetch_operand;
                    end else begin
                        alu_op <= 8'h00;
                        alu_x  <= 4'h0;
                        alu_y  <= 4'h0;
                    end
                end
                ST_EXEC: begin
                    pc     <= pc + 3'd1;
                    alu_op <= 8'h00;
                    alu_x  <= 4'h0;
                    alu_y  <= 4'h0;
                    if (exec_op <= OP_ALU_MAX) begin
                        result <= alu_result;
                        acc    <= alu_result[3:0];
                        if ((exec_op == OP_ADD || exec_op == OP_MUL) && alu_result[7:4] != 4'h0) begin
                            ovf <= 1'b1;
                        end
                    end else if (exec_op == OP_LDI) begin
                        acc    <= ir[3:0];
                        result <= {4'h0, ir[3:0]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a small behavioural ALU
// answering the sequencer's alu_op/alu_x/alu_y requests.
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       prog_we;
    logic [2:0] prog_addr;
    logic [7:0] prog_data;
    logic       start;
    logic [7:0] alu_op;
    logic [3:0] alu_x;
    logic [3:0] alu_y;
    logic [7:0] alu_result;
    logic [3:0] acc;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic       err;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    logic saw_div;

    alu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start      (start),
        .alu_op     (alu_op),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_result (alu_result),
        .acc        (acc),
        .result     (result),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: add, sub, mul, div on 8-bit widened operands, xor otherwise.
    always_comb begin
        alu_result = 8'h00;
        case (alu_op[3:0])
            4'd0: alu_result = {4'h0, alu_x} + {4'h0, alu_y};
            4'd1: alu_result = {4'h0, alu_x} - {4'h0, alu_y};
            4'd2: alu_result = {4'h0, alu_x} * {4'h0, alu_y};
            4'd3: alu_result = (alu_y == 4'h0) ? 8'hFF : {4'h0, alu_x} / {4'h0, alu_y};
            default: alu_result = {4'h0, alu_x ^ alu_y};
        endcase
    end

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (alu_op[3:0] == 4'd3) saw_div = 1'b1;
    endtask

    task automatic load(input logic [2:0] addr, input logic [7:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = 3'd0;
        prog_data = 8'h00;
        start     = 1'b0;
        saw_div   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_alu_op", alu_op, 8'h00);
        check("rst_acc", {4'h0, acc}, 8'h00);
        check("rst_result", result, 8'h00);
        check("rst_flags", {4'h0, busy, done, err, ovf}, 8'h00);

        // LDI 5, ADD 3, HALT
        load(3'd0, 8'hD5);
        load(3'd1, 8'h03);
        load(3'd2, 8'hF0);
        launch();                                   // edge N
        check("p1_busy", {7'h0, busy}, 8'h01);
        tick();                                     // N+1 EXEC LDI
        check("p1_ldi_alu_op", alu_op, 8'h00);
        tick();                                     // N+2 FETCH ADD
        check("p1_acc_ldi", {4'h0, acc}, 8'h05);
        tick();                                     // N+3 EXEC ADD
        check("p1_add_op", alu_op, 8'h00);
        check("p1_add_x", {4'h0, alu_x}, 8'h05);
        check("p1_add_y", {4'h0, alu_y}, 8'h03);
        tick();                                     // N+4 FETCH HALT
        check("p1_not_done_yet", {7'h0, done}, 8'h00);
        check("p1_alu_y_cleared", {4'h0, alu_y}, 8'h00);
        tick();                                     // N+5 DONE
        check("p1_done", {6'h0, done, busy}, 8'h02);
        check("p1_acc", {4'h0, acc}, 8'h08);
        check("p1_result", result, 8'h08);
        check("p1_ovf", {7'h0, ovf}, 8'h00);

        // LDI 2, SUB 5, HALT
        load(3'd0, 8'hD2);
        load(3'd1, 8'h15);
        launch();
        check("p2_cleared", {result[3:0], busy, done, err, ovf}, 8'h08);
        tick();
        tick();
        tick();
        check("p2_sub_op", alu_op, 8'h01);
        check("p2_sub_xy", {alu_x, alu_y}, 8'h25);
        tick();
        tick();
        check("p2_done", {7'h0, done}, 8'h01);
        check("p2_result", result, 8'hFD);
        check("p2_acc", {4'h0, acc}, 8'h0D);
        check("p2_ovf", {7'h0, ovf}, 8'h00);

        // LDI 15, MUL 15, HALT
        load(3'd0, 8'hDF);
        load(3'd1, 8'h2F);
        launch();
        for (int i = 0; i < 5; i++) tick();
        check("p3_done", {7'h0, done}, 8'h01);
        check("p3_acc", {4'h0, acc}, 8'h01);
        check("p3_result", result, 8'hE1);
        check("p3_ovf", {7'h0, ovf}, 8'h01);

        // LDI 9, DIV 0 -> ERROR
        load(3'd0, 8'hD9);
        load(3'd1, 8'h30);
        saw_div = 1'b0;
        launch();
        check("p4_ovf_cleared", {7'h0, ovf}, 8'h00);
        tick();
        tick();
        tick();                                     // N+3 ERROR
        check("p4_err", {4'h0, busy, done, err, 1'b0}, 8'h02);
        check("p4_acc", {4'h0, acc}, 8'h09);
        check("p4_result", result, 8'h09);
        tick();
        check("p4_err_holds", {7'h0, err}, 8'h01);
        check("p4_no_div_drive", {7'h0, saw_div}, 8'h00);

        // Eight NOPs, with start and a program write attempted mid-run
        for (int i = 0; i < 8; i++) load(3'(i), 8'hE0);
        launch();                                   // edge N
        tick();
        check("p5_nop_alu_op", alu_op, 8'h00);
        tick();
        tick();
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 3'd7;
        prog_data = 8'hF0;
        tick();                                     // N+4
        prog_we   = 1'b0;
        tick();                                     // N+5, start alone while busy
        start     = 1'b0;
        for (int i = 0; i < 10; i++) tick();        // N+15
        check("p5_busy_at_15", {6'h0, busy, done}, 8'h02);
        tick();                                     // N+16
        check("p5_done_at_16", {6'h0, busy, done}, 8'h01);
        check("p5_acc", {4'h0, acc}, 8'h00);

        // Write and start together in DONE: write wins, start dropped
        prog_we   = 1'b1;
        start     = 1'b1;
        prog_addr = 3'd0;
        prog_data = 8'hD3;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        check("wr_prio_no_start", {6'h0, busy, done}, 8'h01);

        // LDI 3, ADD 4, SUB 1, HALT; reset during EXEC of ADD
        load(3'd1, 8'h04);
        load(3'd2, 8'h11);
        load(3'd3, 8'hF0);
        launch();
        tick();
        tick();
        tick();                                     // N+3 EXEC ADD
        check("p6_add_xy", {alu_x, alu_y}, 8'h34);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("p6_rst_alu", {alu_op[3:0], alu_x}, 8'h00);
        check("p6_rst_alu_y", {4'h0, alu_y}, 8'h00);
        check("p6_rst_data", {acc, 4'h0}, 8'h00);
        check("p6_rst_result", result, 8'h00);
        check("p6_rst_flags", {4'h0, busy, done, err, ovf}, 8'h00);
        launch();
        tick();                                     // mem[0] is HALT after reset
        check("p6_mem_halt", {6'h0, busy, done}, 8'h01);
        check("p6_mem_halt_acc", {4'h0, acc}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: prog_we  in  1  program-memory write strobe; prog_addr  in  3  write address; prog_data  in  8  instruction word, [7:4] opcode, [3:0] operand.
REQ-004 SHALL have: start  in  1  run request, sampled each cycle.
REQ-005 SHALL have: alu_op  out  8  ALU select; alu_x  out  4  x operand; alu_y  out  4  y operand; alu_result  in  8  combinational ALU result.
REQ-006 SHALL have: acc  out  4  accumulator; result  out  8  last captured alu_result; busy, done, err, ovf  out  1 each  status flags.

Function
REQ-007 SHALL hold an 8x8 program memory, written only when prog_we=1 and state is IDLE, DONE or ERROR; writes in FETCH/EXEC are ignored.
REQ-008 SHALL implement states IDLE, FETCH, EXEC, DONE, ERROR; busy=1 exactly in FETCH and EXEC.
REQ-009 SHALL accept start in IDLE, DONE or ERROR only when prog_we=0 that cycle (write has priority, start dropped); accept -> pc=0, acc=0, result=0, done=err=ovf=0, next state FETCH.
REQ-010 SHALL ignore start while busy.
REQ-011 FETCH SHALL load ir from mem[pc]: opcode 15 (HALT) -> DONE; opcode 3 or 10 with operand 0 -> ERROR (err=1, acc/result unchanged); otherwise -> EXEC.
REQ-012 SHALL drive registered alu_op={4'h0,ir[7:4]}, alu_x=acc, alu_y=ir[3:0] during EXEC for opcodes 0-12; all three SHALL be 0 in every other state and for opcodes 13-14.
REQ-013 EXEC, opcodes 0-12: result<=alu_result, acc<=alu_result[3:0]; opcodes 0 and 2 with alu_result[7:4]!=0 SHALL set sticky ovf.
REQ-014 EXEC, opcode 13 (LDI): acc<=operand, result<={4'h0,operand}; opcode 14 (NOP): no state change beyond pc.
REQ-015 EXEC SHALL increment pc; if pc was 7 it wraps to 0 and next state is DONE, else FETCH.
REQ-016 Latency: each non-HALT instruction SHALL take exactly 2 cycles (FETCH+EXEC); HALT or divide-by-zero SHALL take 1 cycle (FETCH).
REQ-017 done=1 exactly in DONE, err=1 exactly in ERROR; both SHALL hold until accepted start or rst.
REQ-018 Opcodes 0-12 SHALL be passed through unmodified; the block SHALL not interpret ALU semantics beyond REQ-011/013.

Reset
REQ-019 rst=1 SHALL force state IDLE, pc=0, ir=0, acc=0, result=0, alu_op=alu_x=alu_y=0, busy=done=err=ovf=0 at next edge, including mid-run.
REQ-020 rst SHALL fill all 8 memory entries with 8'hF0 (HALT); rst has priority over prog_we and start.

Verification
REQ-021 Load [0]=8'hD5 (LDI 5), [1]=8'h03 (ADD 3), [2]=8'hF0; start at edge N -> EXEC of ADD shows alu_op=0, alu_x=5, alu_y=3; done=1 after edge N+5; acc=8, result=8'h08, ovf=0.
REQ-022 Program LDI 2, SUB 5 (8'h15), HALT; external ALU returns 8'hFD -> result=8'hFD, acc=4'hD, ovf=0, done=1.
REQ-023 Program LDI 15, MUL 15 (8'h2F), HALT; ALU returns 8'hE1 -> acc=1, result=8'hE1, ovf=1; next start clears ovf.
REQ-024 Program LDI 9, DIV 0 (8'h30) -> ERROR after FETCH of pc=1, err=1, acc=9, alu_op/x/y never show op 3.
REQ-025 All 8 entries 8'hE0 (NOP) -> done=1 16 cycles after start accepted, pc=0, acc=0.
REQ-026 rst pulsed during EXEC of a 4-instruction program -> all outputs 0 next cycle, memory reads back HALT; start pulsed while busy and prog_we while busy have no effect.
